// File: rtl/i2c_regbank_pkg.sv
// Shared types and width defaults for the I2C register-bank arbiter.
// No logic: types and constants only.
// No handshake of its own.
package i2c_regbank_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        ST_IDLE,
        ST_RD_WAIT
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_I2C_WR,
        SRC_I2C_RD,
        SRC_HOST
    } src_t;

endpackage

// File: rtl/i2c_regbank_arbiter_if.sv
// Bundle of I2C slave, host and RAM signals around the register-bank arbiter.
// Wiring only: adds no latency.
// Host uses req/gnt; I2C pulses cannot be stalled.
interface i2c_regbank_arbiter_if import i2c_regbank_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              i2c_wr_en_i;
    logic [ADDR_W-1:0] i2c_wr_addr_i;
    logic [DATA_W-1:0] i2c_wr_data_i;
    logic              i2c_rd_en_i;
    logic [ADDR_W-1:0] i2c_rd_addr_i;
    logic [DATA_W-1:0] i2c_rd_data_o;
    logic              i2c_ovf_o;

    logic              host_req_i;
    logic              host_we_i;
    logic [ADDR_W-1:0] host_addr_i;
    logic [DATA_W-1:0] host_wdata_i;
    logic              host_gnt_o;
    logic              host_rvalid_o;
    logic [DATA_W-1:0] host_rdata_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  i2c_wr_en_i, i2c_wr_addr_i, i2c_wr_data_i, i2c_rd_en_i, i2c_rd_addr_i,
        output i2c_rd_data_o, i2c_ovf_o,
        input  host_req_i, host_we_i, host_addr_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output i2c_wr_en_i, i2c_wr_addr_i, i2c_wr_data_i, i2c_rd_en_i, i2c_rd_addr_i,
        input  i2c_rd_data_o, i2c_ovf_o,
        output host_req_i, host_we_i, host_addr_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/i2c_req_slot.sv
// One-deep pending-request register for an unstallable pulse source.
// Loads at the edge after the pulse; visible to the arbiter one cycle later.
// No backpressure: a new pulse overwrites a pending one and sets sticky ovf.
module i2c_req_slot #(
    parameter int W = 8
) (
    input  logic         sys_clk_i,
    input  logic         rst_i,
    input  logic         ld,
    input  logic [W-1:0] ld_dat,
    input  logic         clr,
    output logic         vld,
    output logic [W-1:0] dat,
    output logic         ovf
);

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld <= 1'b0;
            dat <= '0;
            ovf <= 1'b0;
        end else if (ld) begin
            // A load in the issue cycle replaces an already-served request, so it is not lost.
            vld <= 1'b1;
            dat <= ld_dat;
            if (vld && !clr) begin
                ovf <= 1'b1;
            end
        end else if (clr) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/i2c_regbank_arbiter.sv
// Shares one single-port RAM between latched I2C requests (priority) and a host port.
// RAM strobe 1 cycle after decision; read result registered RD_LATENCY+1 cycles after the strobe.
// Host held off via gnt while I2C slots are pending or a read is outstanding.
module i2c_regbank_arbiter import i2c_regbank_pkg::*; #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 1
) (
    input logic                  sys_clk_i,
    input logic                  rst_i,
    i2c_regbank_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam int WR_W  = ADDR_W + DATA_W;

    logic              wr_vld, wr_clr, wr_ovf;
    logic [WR_W-1:0]   wr_dat;
    logic              rd_vld, rd_clr, rd_ovf;
    logic [ADDR_W-1:0] rd_addr;

    state_t            state;
    src_t              tag;
    src_t              sel;
    logic [CNT_W-1:0]  cnt;

    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic [DATA_W-1:0] i2c_rd_data;

    i2c_req_slot #(.W(WR_W)) u_wr_slot (
        .sys_clk_i (sys_clk_i),
        .rst_i     (rst_i),
        .ld        (bus.i2c_wr_en_i),
        .ld_dat    ({bus.i2c_wr_addr_i, bus.i2c_wr_data_i}),
        .clr       (wr_clr),
        .vld       (wr_vld),
        .dat       (wr_dat),
        .ovf       (wr_ovf)
    );

    i2c_req_slot #(.W(ADDR_W)) u_rd_slot (
        .sys_clk_i (sys_clk_i),
        .rst_i     (rst_i),
        .ld        (bus.i2c_rd_en_i),
        .ld_dat    (bus.i2c_rd_addr_i),
        .clr       (rd_clr),
        .vld       (rd_vld),
        .dat       (rd_addr),
        .ovf       (rd_ovf)
    );

    // Decision uses only registered slot state, so a same-cycle I2C pulse cannot block a host grant.
    always_comb begin
        sel = SRC_NONE;
        if (state == ST_IDLE) begin
            if (wr_vld) begin
                sel = SRC_I2C_WR;
            end else if (rd_vld) begin
                sel = SRC_I2C_RD;
            end else if (bus.host_req_i) begin
                sel = SRC_HOST;
            end
        end
    end

    assign wr_clr         = (sel == SRC_I2C_WR);
    assign rd_clr         = (sel == SRC_I2C_RD);
    assign bus.host_gnt_o = (sel == SRC_HOST);

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            tag         <= SRC_NONE;
            cnt         <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
            i2c_rd_data <= '0;
        end else begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            host_rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    case (sel)
                        SRC_I2C_WR: begin
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= wr_dat[WR_W-1 -: ADDR_W];
                            mem_wdata <= wr_dat[DATA_W-1:0];
                        end
                        SRC_I2C_RD: begin
                            mem_en   <= 1'b1;
                            mem_addr <= rd_addr;
                            tag      <= SRC_I2C_RD;
                            cnt      <= '0;
                            state    <= ST_RD_WAIT;
                        end
                        SRC_HOST: begin
                            mem_en   <= 1'b1;
                            mem_addr <= bus.host_addr_i;
                            if (bus.host_we_i) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= bus.host_wdata_i;
                            end else begin
                                tag   <= SRC_HOST;
                                cnt   <= '0;
                                state <= ST_RD_WAIT;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_RD_WAIT: begin
                    // cnt==0 is the strobe cycle, so data is present when cnt reaches RD_LATENCY.
                    if (cnt == CNT_W'(RD_LATENCY)) begin
                        if (tag == SRC_HOST) begin
                            host_rdata  <= bus.mem_rdata_i;
                            host_rvalid <= 1'b1;
                        end else begin
                            i2c_rd_data <= bus.mem_rdata_i;
                        end
                        tag   <= SRC_NONE;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_en_o      = mem_en;
    assign bus.mem_we_o      = mem_we;
    assign bus.mem_addr_o    = mem_addr;
    assign bus.mem_wdata_o   = mem_wdata;
    assign bus.host_rvalid_o = host_rvalid;
    assign bus.host_rdata_o  = host_rdata;
    assign bus.i2c_rd_data_o = i2c_rd_data;
    assign bus.i2c_ovf_o     = wr_ovf | rd_ovf;

endmodule
